sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Sequences and shares the single 2K x 8 asynchronous SRAM between two requesters: port 0 (processor PIO bridge) and port 1 (secondary engine, e.g. fill/scan DMA).
- Round-robin arbitration; each granted access runs a fixed SETUP/ACCESS/HOLD timing sequence.
- Drives the SRAM's active-low we/oe strobes; the top level builds the tri-state data bus from sram_wdata and sram_drive.

Parameters:
- ADDR_W, 11, SRAM address width.
- DATA_W, 8, SRAM data width.
- ACCESS_CYCLES, 1, cycles the we/oe strobe is held low (>=1).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  synchronous, active-low reset.
- req0  in  1  port 0 request; hold high until ack0.
- wr0  in  1  port 0 direction: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  DATA_W  port 0 read data; valid from the ack0 cycle and held until port 0's next read completes.
- req1, wr1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  data the controller drives onto the SRAM bus.
- sram_drive  out  1  1 = controller drives the bus; 0 = bus tri-stated.
- sram_rdata  in  DATA_W  SRAM bus as seen by the controller.
- we  out  1  SRAM write enable, active-low.
- oe  out  1  SRAM output enable, active-low.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- All outputs are registered, or decoded from the registered state only.
- States: IDLE, SETUP, ACCESS, HOLD.
- Reset (rst=0 at a clk edge, in any state, including mid-access):
  - state=IDLE, we=1, oe=1, sram_drive=0.
  - sram_addr=0, sram_wdata=0, ack0=ack1=0, rdata0=rdata1=0, busy=0.
  - Priority pointer set to port 0.
  - Any aborted access produces no ack.
- IDLE:
  - Sample req0/req1.
  - Neither high: stay in IDLE.
  - One high: grant that port.
  - Both high: grant the port named by the pointer.
  - On grant, latch the winner's wr, addr and wdata, record the owner, then go to SETUP.
  - Pointer update on any grant: pointer := the other port.
- SETUP (1 cycle):
  - sram_addr holds the latched address; we=1, oe=1.
  - sram_drive = latched wr; sram_wdata = latched data.
  - Next state: ACCESS.
- ACCESS (ACCESS_CYCLES cycles, counted by an internal down-counter):
  - Write: we=0, oe=1, sram_drive=1.
  - Read: oe=0, we=1, sram_drive=0.
  - Address and data stay stable throughout.
  - On the clk edge ending the last ACCESS cycle, a read captures sram_rdata into the owner's rdata register.
  - Next state: HOLD.
- HOLD (1 cycle):
  - we=1, oe=1; address and sram_drive are held unchanged, giving write data hold time.
  - The owner's ack is 1 in this cycle only.
  - Next state: IDLE, with sram_drive=0 there.
- Latency:
  - A request sampled at edge E gives ack in the cycle starting at edge E + 2 + ACCESS_CYCLES.
  - Access period is 3 + ACCESS_CYCLES cycles.
  - Minimum IDLE-to-IDLE spacing is 1 IDLE cycle.
- Requester rule:
  - req, wr, addr and wdata must stay stable from assertion until ack.
  - req must be low in the cycle after ack; a req still high in IDLE is treated as a new request.
- Requests arriving while busy=1 wait; they are never dropped.
- With both ports requesting continuously, grants alternate 0,1,0,1...
- A port never waits more than one full access by the other port.
- we and oe are never 0 in the same cycle.
- sram_drive=1 is only permitted when oe=1.
- Address wrap: none; addresses are passed through unmodified, including 0 and 2^ADDR_W-1.

Test Plan:
- Reset, then port 0 write addr=0x005 data=0xA5 -> sram_addr=0x005 from SETUP; we=0 for exactly 1 cycle; sram_drive=1 through SETUP/ACCESS/HOLD; ack0 3 cycles after sampling; ack1 never asserted.
- Port 1 read addr=0x005 after that write (SRAM model attached) -> oe=0 for 1 cycle; rdata1=0xA5 in the ack1 cycle; sram_drive=0 throughout.
- req0 and req1 both high from reset, looped for 8 accesses -> grant order 0,1,0,1,0,1,0,1; never two grants in one access period; no ack overlap.
- ACCESS_CYCLES=3, write to 0x7FF then read from 0x7FF -> strobe low for 3 cycles; ack at sample+5; read returns the written data; addr 0x7FF is not truncated.
- rst=0 asserted during ACCESS of a write -> next cycle IDLE with we=1, oe=1, sram_drive=0, busy=0, no ack; after release, port 0 wins a simultaneous request.
- Every cycle of all runs: assert !(we==0 && oe==0) and !(sram_drive && oe==0).

Source files
------------

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one asynchronous 2K x 8 SRAM between two requesters with
// round-robin arbitration. Each granted access runs a fixed
// SETUP / ACCESS / HOLD sequence on the SRAM strobes. The top level builds
// the tri-state data bus from sram_wdata and sram_drive.
//
// Ports:
//   clk, rst            system clock, synchronous active-low reset
//   req0/wr0/addr0/wdata0 -> ack0/rdata0   port 0 request interface
//   req1/wr1/addr1/wdata1 -> ack1/rdata1   port 1 request interface
//   sram_addr           SRAM address
//   sram_wdata          data driven onto the SRAM bus
//   sram_drive          1 = controller drives the bus, 0 = tri-stated
//   sram_rdata          SRAM bus as seen by the controller
//   we, oe              SRAM write / output enables, active-low
//   busy                1 whenever an access is in progress
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W        = 11,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_drive,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              we,
    output logic              oe,
    output logic              busy
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             lat_wr;
    logic             owner;
    logic             pri;
    logic             grant;
    logic             grant_port;

    // State register. Reset drops any access in flight, so an aborted
    // access never reaches HOLD and never produces an ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe decode. The strobes and acks depend only on
    // registered state, so they are glitch-free with respect to the request
    // inputs. In IDLE a tie between both ports goes to the port named by the
    // round-robin pointer; a lone request is granted directly.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_port = 1'b0;
        we         = 1'b1;
        oe         = 1'b1;
        ack0       = 1'b0;
        ack1       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    grant_port = (req0 && req1) ? pri : req1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                we = ~lat_wr;
                oe = lat_wr;
                if (cnt == '0) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                ack0       = ~owner;
                ack1       = owner;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latches the winning request at grant time and keeps address,
    // data and bus direction stable until the access ends. sram_drive stays
    // up through HOLD so write data has hold time after we rises, then drops
    // on the way back to IDLE. The access counter is loaded in SETUP and
    // counts down to zero across the ACCESS cycles; read data is captured on
    // the edge that ends the last ACCESS cycle while oe is still low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            lat_wr     <= 1'b0;
            owner      <= 1'b0;
            pri        <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_drive <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            if (grant) begin
                owner      <= grant_port;
                pri        <= ~grant_port;
                lat_wr     <= grant_port ? wr1 : wr0;
                sram_addr  <= grant_port ? addr1 : addr0;
                sram_wdata <= grant_port ? wdata1 : wdata0;
                sram_drive <= grant_port ? wr1 : wr0;
            end
            if (state == SETUP) begin
                cnt <= CNT_LOAD;
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if ((state == ACCESS) && (cnt == '0) && !lat_wr) begin
                if (owner) begin
                    rdata1 <= sram_rdata;
                end else begin
                    rdata0 <= sram_rdata;
                end
            end
            if (state == HOLD) begin
                sram_drive <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//
// Bench for sram_arbiter. Two instances share clock and reset: instance A
// with ACCESS_CYCLES=1 and instance B with ACCESS_CYCLES=3. Each instance
// has a behavioural SRAM attached. Expected acks, latencies, strobe counts
// and read data come from a transaction-level model: a priority port,
// a reference memory and the last value read per port.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int AW   = 11;
    localparam int DW   = 8;
    localparam int AC_A = 1;
    localparam int AC_B = 3;

    logic clk = 1'b0;
    logic rst;

    // Instance A signals
    logic          req0, wr0, req1, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic          sram_drive, we, oe, busy;

    // Instance B signals
    logic          b_req0, b_wr0, b_req1, b_wr1;
    logic [AW-1:0] b_addr0, b_addr1;
    logic [DW-1:0] b_wdata0, b_wdata1;
    logic          b_ack0, b_ack1;
    logic [DW-1:0] b_rdata0, b_rdata1;
    logic [AW-1:0] b_sram_addr;
    logic [DW-1:0] b_sram_wdata, b_sram_rdata;
    logic          b_sram_drive, b_we, b_oe, b_busy;

    // Behavioural SRAMs and the reference model state
    logic [DW-1:0] mem_a [2048];
    logic [DW-1:0] mem_b [2048];
    logic [DW-1:0] ref_mem [2][2048];
    logic [DW-1:0] last_rd [2][2];
    bit            pri_m [2];

    int tests;
    int fails;
    bit mon_en;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC_A)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_drive(sram_drive),
        .sram_rdata(sram_rdata), .we(we), .oe(oe), .busy(busy)
    );

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC_B)) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .wr0(b_wr0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
        .req1(b_req1), .wr1(b_wr1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
        .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_drive(b_sram_drive),
        .sram_rdata(b_sram_rdata), .we(b_we), .oe(b_oe), .busy(b_busy)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Asynchronous SRAMs: read data appears while oe is low, and a write
    // lands on the clock edge where we is still low (the rising we edge).
    assign sram_rdata   = (oe === 1'b0) ? mem_a[sram_addr] : '0;
    assign b_sram_rdata = (b_oe === 1'b0) ? mem_b[b_sram_addr] : '0;

    always @(posedge clk) begin
        if (we === 1'b0) mem_a[sram_addr] <= sram_wdata;
        if (b_we === 1'b0) mem_b[b_sram_addr] <= b_sram_wdata;
    end

    // Every cycle: the strobes must never both be low, and the controller
    // must never drive the bus while the SRAM outputs are enabled.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("a.we_oe_both_low", 32'(we === 1'b0 && oe === 1'b0), 32'd0);
            checkOutput("a.drive_while_oe", 32'(sram_drive === 1'b1 && oe === 1'b0), 32'd0);
            checkOutput("b.we_oe_both_low", 32'(b_we === 1'b0 && b_oe === 1'b0), 32'd0);
            checkOutput("b.drive_while_oe", 32'(b_sram_drive === 1'b1 && b_oe === 1'b0), 32'd0);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return AW'($urandom_range(0, 15));
        endcase
    endfunction

    // Runs one arbitration round on instance A (big=0) or B (big=1): the
    // selected ports raise their requests together in an IDLE cycle, each
    // request is dropped as soon as its ack is seen, and the observed acks,
    // strobe activity and read data are compared with the model.
    task automatic applyStimulus(input string lbl, input bit big, input bit r0, input bit r1,
                                 input bit w0, input bit w1,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int            ac;
        int            first;
        int            n_wr;
        int            n_rd;
        int            we_lo;
        int            oe_lo;
        int            drv_hi;
        int            overlap;
        int            exp_at [2];
        int            got_at [2];
        int            order [$];
        logic [DW-1:0] got_rd [2];
        logic [AW-1:0] setup_addr;
        logic [AW-1:0] exp_setup;
        bit            pend [2];
        bit            wr [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] dt [2];
        logic          av [2];

        ac = big ? AC_B : AC_A;
        wr[0] = w0; wr[1] = w1;
        ad[0] = a0; ad[1] = a1;
        dt[0] = d0; dt[1] = d1;

        // Read registers must still hold the last completed read
        checkOutput({lbl, ".rdata0_held"}, 32'(big ? b_rdata0 : rdata0), 32'(last_rd[big][0]));
        checkOutput({lbl, ".rdata1_held"}, 32'(big ? b_rdata1 : rdata1), 32'(last_rd[big][1]));

        // Model: grant order, ack times and memory effects per transaction
        first = (r0 && r1) ? int'(pri_m[big]) : (r1 ? 1 : 0);
        if (r0 && r1) order = '{first, 1 - first};
        else order = '{first};
        exp_at = '{-1, -1};
        n_wr = 0;
        n_rd = 0;
        foreach (order[i]) begin
            int p;
            p = order[i];
            exp_at[p] = 2 + ac + i * (3 + ac);
            if (wr[p]) begin
                ref_mem[big][ad[p]] = dt[p];
                n_wr++;
            end else begin
                last_rd[big][p] = ref_mem[big][ad[p]];
                n_rd++;
            end
            pri_m[big] = (p == 0);
        end
        exp_setup = ad[first];

        @(posedge clk);
        #1;
        if (big) begin
            b_req0 = r0; b_wr0 = w0; b_addr0 = a0; b_wdata0 = d0;
            b_req1 = r1; b_wr1 = w1; b_addr1 = a1; b_wdata1 = d1;
        end else begin
            req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
            req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
        end
        pend[0] = r0;
        pend[1] = r1;
        got_at = '{-1, -1};
        got_rd = '{default: '0};
        we_lo = 0; oe_lo = 0; drv_hi = 0; overlap = 0;
        setup_addr = '0;

        for (int k = 0; k < 60 && (pend[0] || pend[1]); k++) begin
            @(negedge clk);
            av[0] = big ? b_ack0 : ack0;
            av[1] = big ? b_ack1 : ack1;
            if ((big ? b_we : we) === 1'b0) we_lo++;
            if ((big ? b_oe : oe) === 1'b0) oe_lo++;
            if ((big ? b_sram_drive : sram_drive) === 1'b1) drv_hi++;
            if (k == 1) setup_addr = big ? b_sram_addr : sram_addr;
            if (av[0] === 1'b1 && av[1] === 1'b1) overlap++;
            if (av[0] === 1'b1) begin
                got_at[0] = k;
                got_rd[0] = big ? b_rdata0 : rdata0;
                pend[0] = 1'b0;
                if (big) b_req0 = 1'b0; else req0 = 1'b0;
            end
            if (av[1] === 1'b1) begin
                got_at[1] = k;
                got_rd[1] = big ? b_rdata1 : rdata1;
                pend[1] = 1'b0;
                if (big) b_req1 = 1'b0; else req1 = 1'b0;
            end
        end
        if (big) begin
            b_req0 = 1'b0; b_req1 = 1'b0;
        end else begin
            req0 = 1'b0; req1 = 1'b0;
        end

        checkOutput({lbl, ".ack0_cycle"}, 32'(got_at[0]), 32'(exp_at[0]));
        checkOutput({lbl, ".ack1_cycle"}, 32'(got_at[1]), 32'(exp_at[1]));
        if (r0) checkOutput({lbl, ".rdata0"}, 32'(got_rd[0]), 32'(last_rd[big][0]));
        if (r1) checkOutput({lbl, ".rdata1"}, 32'(got_rd[1]), 32'(last_rd[big][1]));
        checkOutput({lbl, ".we_low_cycles"}, 32'(we_lo), 32'(n_wr * ac));
        checkOutput({lbl, ".oe_low_cycles"}, 32'(oe_lo), 32'(n_rd * ac));
        checkOutput({lbl, ".drive_cycles"}, 32'(drv_hi), 32'(n_wr * (2 + ac)));
        checkOutput({lbl, ".ack_overlap"}, 32'(overlap), 32'd0);
        checkOutput({lbl, ".setup_addr"}, 32'(setup_addr), 32'(exp_setup));
    endtask

    // Directed sequence followed by randomized rounds on both instances
    initial begin
        bit seen;
        int pat;

        tests = 0;
        fails = 0;
        mon_en = 1'b0;
        rst = 1'b0;
        req0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0; req1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
        b_req0 = 0; b_wr0 = 0; b_addr0 = '0; b_wdata0 = '0; b_req1 = 0; b_wr1 = 0; b_addr1 = '0; b_wdata1 = '0;
        for (int i = 0; i < 2048; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
            ref_mem[0][i] = '0;
            ref_mem[1][i] = '0;
        end
        last_rd = '{default: '0};
        pri_m = '{default: 1'b0};

        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        checkOutput("reset.we", 32'(we), 32'd1);
        checkOutput("reset.oe", 32'(oe), 32'd1);
        checkOutput("reset.sram_drive", 32'(sram_drive), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.ack0", 32'(ack0), 32'd0);
        checkOutput("reset.ack1", 32'(ack1), 32'd0);
        checkOutput("reset.sram_addr", 32'(sram_addr), 32'd0);
        checkOutput("reset.sram_wdata", 32'(sram_wdata), 32'd0);
        checkOutput("reset.rdata0", 32'(rdata0), 32'd0);
        checkOutput("reset.rdata1", 32'(rdata1), 32'd0);
        checkOutput("reset.b_busy", 32'(b_busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Both ports requesting from reset: grants alternate 0,1,0,1...
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("both%0d", i), 1'b0, 1'b1, 1'b1,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          rand_addr(), rand_addr(), 8'($urandom), 8'($urandom));
        end

        // Port 0 write then port 1 read of the same location
        applyStimulus("wr5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'h005, 11'h000, 8'hA5, 8'h00);
        applyStimulus("rd5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h005, 8'h00, 8'h00);

        // Longer strobe: top address write then read on instance B
        applyStimulus("b_wr7ff", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'h7FF, 11'h000, 8'h5E, 8'h00);
        applyStimulus("b_rd7ff", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h7FF, 8'h00, 8'h00);

        // Reset in the middle of a write: port 0 is granted first so the
        // pointer favours port 1 right before the abort.
        applyStimulus("pre_abort", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h00A, 11'h000, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 11'h123; wdata0 = 8'h3C;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (we === 1'b0) seen = 1'b1;
        end
        checkOutput("abort.reached_access", 32'(seen), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort.we", 32'(we), 32'd1);
        checkOutput("abort.oe", 32'(oe), 32'd1);
        checkOutput("abort.sram_drive", 32'(sram_drive), 32'd0);
        checkOutput("abort.busy", 32'(busy), 32'd0);
        checkOutput("abort.ack0", 32'(ack0), 32'd0);
        req0 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        // The SRAM still saw the rising we edge at the reset edge, so the
        // aborted write reached memory; reset itself clears both instances'
        // pointers and read registers.
        ref_mem[0][11'h123] = 8'h3C;
        pri_m = '{default: 1'b0};
        last_rd = '{default: '0};
        applyStimulus("post_abort", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'h123, 11'h005, 8'h00, 8'h00);

        // Randomized rounds on both instances
        for (int i = 0; i < 24; i++) begin
            pat = $urandom_range(1, 3);
            applyStimulus($sformatf("rnd%0d", i), 1'b0, pat[0], pat[1],
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          rand_addr(), rand_addr(), 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 8; i++) begin
            pat = $urandom_range(1, 3);
            applyStimulus($sformatf("b_rnd%0d", i), 1'b1, pat[0], pat[1],
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          rand_addr(), rand_addr(), 8'($urandom), 8'($urandom));
        end

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
